// File: rtl/ycc_pkg.sv
// Shared types and constants for the 4:2:2 -> 4:4:4 chroma upsampler.
package ycc_pkg;
  localparam int PIX_W = 8;
  localparam logic [PIX_W-1:0] C_NEUTRAL = 8'd128;

  // One decoded luma pair with its shared chroma. odd marks a line that
  // ended on a Cb word: only y0 is real and a single pixel is emitted.
  typedef struct packed {
    logic [PIX_W-1:0] y0;
    logic [PIX_W-1:0] y1;
    logic [PIX_W-1:0] cb;
    logic [PIX_W-1:0] cr;
    logic             last;
    logic             odd;
  } pair_t;

  typedef enum logic {
    EMIT0 = 1'b0,
    EMIT1 = 1'b1
  } emit_e;
endpackage

// File: rtl/ycbcr422_to_444_if.sv
// Stream bundle for the upsampler: 4:2:2 words in, 4:4:4 pixels out.
interface ycbcr422_to_444_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_last;

  // Environment side: produces 4:2:2 words, consumes 4:4:4 pixels.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  // Upsampler side.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ycbcr422_to_444_avg.sv
// Rounding average of two chroma samples; the 9-bit sum keeps the carry
// so the result is always within 0..255.
module chroma_avg
  import ycc_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] y
);
  logic [PIX_W:0] sum;

  // (a + b + 1) >> 1
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{PIX_W{1'b0}}, 1'b1};
    y   = sum[PIX_W:1];
  end
endmodule

// File: rtl/ycbcr422_to_444.sv
// Streaming 4:2:2 -> 4:4:4 chroma upsampler. Words are paired into the
// P/Q slots; P is emitted as two pixels (one for an odd line tail).
module ycbcr422_to_444
  import ycc_pkg::*;
#(
  parameter bit INTERP = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  ycbcr422_to_444_if.slave        bus,
  output logic                    err_odd
);
  logic              ph_q, ph_d;
  logic [PIX_W-1:0]  h_y_q, h_y_d, h_cb_q, h_cb_d;
  pair_t             p_q, p_d, q_q, q_d;
  logic              p_valid_q, p_valid_d, q_valid_q, q_valid_d;
  emit_e             st_q, st_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [23:0]       m_data_q, m_data_d;
  logic              err_q, err_d;

  logic              acc, new_vld;
  pair_t             new_pair;
  logic [PIX_W-1:0]  w_c, w_y, avg_cb, avg_cr;
  logic              pix_vld, pix_last, pix_done, load;
  logic [23:0]       pix_data;

  assign bus.s_ready = !q_valid_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign err_odd     = err_q;

  chroma_avg u_avg_cb (.a(p_q.cb), .b(q_q.cb), .y(avg_cb));
  chroma_avg u_avg_cr (.a(p_q.cr), .b(q_q.cr), .y(avg_cr));

  // Accept a word and form a completed pair (Cr word, or Cb word ending a line)
  always_comb begin
    acc     = bus.s_valid && !q_valid_q;
    w_c     = bus.s_data[15:8];
    w_y     = bus.s_data[7:0];
    new_vld = acc && (ph_q || bus.s_last);
    new_pair = '0;
    if (ph_q) begin
      new_pair.y0   = h_y_q;
      new_pair.y1   = w_y;
      new_pair.cb   = h_cb_q;
      new_pair.cr   = w_c;
      new_pair.last = bus.s_last;
      new_pair.odd  = 1'b0;
    end else begin
      new_pair.y0   = w_y;
      new_pair.y1   = w_y;
      new_pair.cb   = w_c;
      new_pair.cr   = C_NEUTRAL;
      new_pair.last = 1'b1;
      new_pair.odd  = 1'b1;
    end
  end

  // Emission FSM output: pick the pixel P offers in the current state
  always_comb begin
    pix_vld  = 1'b0;
    pix_data = '0;
    pix_last = 1'b0;
    pix_done = 1'b0;
    if (p_valid_q) begin
      if (p_q.odd) begin
        pix_vld  = 1'b1;
        pix_data = {p_q.y0, p_q.cb, C_NEUTRAL};
        pix_last = 1'b1;
        pix_done = 1'b1;
      end else if (st_q == EMIT0) begin
        pix_vld  = 1'b1;
        pix_data = {p_q.y0, p_q.cb, p_q.cr};
      end else if (INTERP == 1'b0 || p_q.last || (q_valid_q && q_q.odd)) begin
        // No usable right-hand neighbour: replicate own chroma
        pix_vld  = 1'b1;
        pix_data = {p_q.y1, p_q.cb, p_q.cr};
        pix_last = p_q.last;
        pix_done = 1'b1;
      end else if (q_valid_q) begin
        pix_vld  = 1'b1;
        pix_data = {p_q.y1, avg_cb, avg_cr};
        pix_last = p_q.last;
        pix_done = 1'b1;
      end
    end
    load = pix_vld && (!m_valid_q || bus.m_ready);
  end

  // Emission FSM next state: advance only when a pixel enters the output reg
  always_comb begin
    st_d = st_q;
    if (load) st_d = pix_done ? EMIT0 : EMIT1;
  end

  // Emission FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= EMIT0;
    else     st_q <= st_d;
  end

  // Phase, half register, pair slots, output register and error flag
  always_comb begin
    ph_d      = ph_q;
    h_y_d     = h_y_q;
    h_cb_d    = h_cb_q;
    p_d       = p_q;
    p_valid_d = p_valid_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    err_d     = err_q;
    if (acc) begin
      ph_d = bus.s_last ? 1'b0 : !ph_q;
      if (!ph_q && !bus.s_last) begin
        h_y_d  = w_y;
        h_cb_d = w_c;
      end
      if (!ph_q && bus.s_last) err_d = 1'b1;
    end
    // Q slides into P on the edge P finishes
    if (load && pix_done) begin
      p_d       = q_q;
      p_valid_d = q_valid_q;
      q_valid_d = 1'b0;
    end
    // New pair lands after the slide: P if it is free, else Q
    if (new_vld) begin
      if (!p_valid_d) begin
        p_d       = new_pair;
        p_valid_d = 1'b1;
      end else begin
        q_d       = new_pair;
        q_valid_d = 1'b1;
      end
    end
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = pix_data;
      m_last_d  = pix_last;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q      <= 1'b0;
      h_y_q     <= '0;
      h_cb_q    <= '0;
      p_q       <= '0;
      p_valid_q <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      h_y_q     <= h_y_d;
      h_cb_q    <= h_cb_d;
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_ycbcr422_to_444.sv
// Bench for the chroma upsampler: dut0 replicates (INTERP=0), dut1
// interpolates (INTERP=1). Expected pixels go to a per-DUT queue when the
// word is driven and are popped as the DUT hands pixels out.
module tb_ycbcr422_to_444;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ycbcr422_to_444_if bus0 ();
  ycbcr422_to_444_if bus1 ();

  logic [1:0]       s_valid, s_last, m_ready;
  logic [1:0][15:0] s_data;
  logic [1:0]       s_ready_o, m_valid_o, m_last_o, err_o;
  logic [1:0][23:0] m_data_o;

  assign bus0.s_valid = s_valid[0];
  assign bus0.s_data  = s_data[0];
  assign bus0.s_last  = s_last[0];
  assign bus0.m_ready = m_ready[0];
  assign bus1.s_valid = s_valid[1];
  assign bus1.s_data  = s_data[1];
  assign bus1.s_last  = s_last[1];
  assign bus1.m_ready = m_ready[1];
  assign s_ready_o = {bus1.s_ready, bus0.s_ready};
  assign m_valid_o = {bus1.m_valid, bus0.m_valid};
  assign m_last_o  = {bus1.m_last, bus0.m_last};
  assign m_data_o  = {bus1.m_data, bus0.m_data};

  ycbcr422_to_444 #(.INTERP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave), .err_odd(err_o[0]));
  ycbcr422_to_444 #(.INTERP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .err_odd(err_o[1]));

  typedef struct {
    int          grp;
    int          d;
    logic [15:0] w;
    logic        l;
    int          n;
    logic [24:0] e0;
    logic [24:0] e1;
  } vec_t;

  vec_t        vecs[$];
  logic [24:0] exp_q0[$];
  logic [24:0] exp_q1[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [24:0] px(input logic l, input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    return {l, y, cb, cr};
  endfunction

  function automatic void add(input int g, input int d, input logic [15:0] w, input logic l,
                              input int n, input logic [24:0] e0, input logic [24:0] e1);
    vec_t v;
    v.grp = g; v.d = d; v.w = w; v.l = l; v.n = n; v.e0 = e0; v.e1 = e1;
    vecs.push_back(v);
  endfunction

  task automatic push_exp(input int d, input logic [24:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Compare every handed-over pixel against the head of the right queue
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          if (m_valid_o[d] && m_ready[d]) begin
            logic [24:0] act, e;
            bit          have;
            act  = {m_last_o[d], m_data_o[d]};
            have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
            n_cmp++;
            if (!have) begin
              n_fail++;
              $display("FAIL pixel_dut%0d: got %h, expected nothing", d, act);
            end else begin
              e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              if (act !== e) begin
                n_fail++;
                $display("FAIL pixel_dut%0d: got {last,Y,Cb,Cr}=%h, expected %h", d, act, e);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic send_word(input int d, input logic [15:0] w, input logic l);
    bit done = 1'b0;
    s_valid[d] = 1'b1;
    s_data[d]  = w;
    s_last[d]  = l;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (s_ready_o[d]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    s_valid[d] = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout_dut%0d: word %h never accepted, expected acceptance", d, w);
    end
  endtask

  task automatic run_grp(input int g);
    foreach (vecs[i]) begin
      if (vecs[i].grp == g) begin
        if (vecs[i].n > 0) push_exp(vecs[i].d, vecs[i].e0);
        if (vecs[i].n > 1) push_exp(vecs[i].d, vecs[i].e1);
        send_word(vecs[i].d, vecs[i].w, vecs[i].l);
      end
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (k >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d/%0d pixels outstanding, expected 0", exp_q0.size(), exp_q1.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Hold dut0 output for 10 cycles mid-line while input keeps streaming
  task automatic stall_check();
    logic [23:0] snap;
    bit stable = 1'b1;
    bit saw_low = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_ready[0] = 1'b0;
    @(negedge clk);
    snap = m_data_o[0];
    repeat (10) begin
      @(negedge clk);
      if (!m_valid_o[0] || m_data_o[0] !== snap) stable = 1'b0;
      if (!s_ready_o[0]) saw_low = 1'b1;
    end
    chk("stall_output_stable", {31'd0, stable}, 32'd1);
    chk("stall_s_ready_dropped", {31'd0, saw_low}, 32'd1);
    @(posedge clk);
    #1 m_ready[0] = 1'b1;
  endtask

  initial begin
    // g1: replicate, test-plan line
    add(1, 0, 16'h4010, 1'b0, 0, '0, '0);
    add(1, 0, 16'hC020, 1'b0, 2, px(0, 8'h10, 8'h40, 8'hC0), px(0, 8'h20, 8'h40, 8'hC0));
    add(1, 0, 16'h5030, 1'b0, 0, '0, '0);
    add(1, 0, 16'hD040, 1'b1, 2, px(0, 8'h30, 8'h50, 8'hD0), px(1, 8'h40, 8'h50, 8'hD0));
    // g2: interpolate, same line
    add(2, 1, 16'h4010, 1'b0, 0, '0, '0);
    add(2, 1, 16'hC020, 1'b0, 0, '0, '0);
    add(2, 1, 16'h5030, 1'b0, 2, px(0, 8'h10, 8'h40, 8'hC0), px(0, 8'h20, 8'h48, 8'hC8));
    add(2, 1, 16'hD040, 1'b1, 2, px(0, 8'h30, 8'h50, 8'hD0), px(1, 8'h40, 8'h50, 8'hD0));
    // g3: rounding and saturation-free extremes
    add(3, 1, 16'h0111, 1'b0, 0, '0, '0);
    add(3, 1, 16'h0012, 1'b0, 0, '0, '0);
    add(3, 1, 16'h0213, 1'b0, 2, px(0, 8'h11, 8'h01, 8'h00), px(0, 8'h12, 8'h02, 8'h01));
    add(3, 1, 16'h0114, 1'b1, 2, px(0, 8'h13, 8'h02, 8'h01), px(1, 8'h14, 8'h02, 8'h01));
    add(3, 1, 16'hFF21, 1'b0, 0, '0, '0);
    add(3, 1, 16'hFF22, 1'b0, 0, '0, '0);
    add(3, 1, 16'hFF23, 1'b0, 2, px(0, 8'h21, 8'hFF, 8'hFF), px(0, 8'h22, 8'hFF, 8'hFF));
    add(3, 1, 16'hFF24, 1'b1, 2, px(0, 8'h23, 8'hFF, 8'hFF), px(1, 8'h24, 8'hFF, 8'hFF));
    // g4: backpressure line
    for (int i = 0; i < 4; i++) begin
      logic [7:0] cb, cr, y0, y1;
      cb = 8'hA0 + 8'(i); cr = 8'hB0 + 8'(i);
      y0 = 8'(2 * i + 1); y1 = 8'(2 * i + 2);
      add(4, 0, {cb, y0}, 1'b0, 0, '0, '0);
      add(4, 0, {cr, y1}, (i == 3), 2, px(0, y0, cb, cr), px(i == 3, y1, cb, cr));
    end
    // g5: odd line, g6: next line starts on Cb
    add(5, 0, 16'h4010, 1'b0, 0, '0, '0);
    add(5, 0, 16'hC020, 1'b0, 2, px(0, 8'h10, 8'h40, 8'hC0), px(0, 8'h20, 8'h40, 8'hC0));
    add(5, 0, 16'h5030, 1'b1, 1, px(1, 8'h30, 8'h50, 8'h80), '0);
    add(6, 0, 16'hA011, 1'b0, 0, '0, '0);
    add(6, 0, 16'hB022, 1'b1, 2, px(0, 8'h11, 8'hA0, 8'hB0), px(1, 8'h22, 8'hA0, 8'hB0));
    // g7: first line after a mid-line reset
    add(7, 1, 16'h6070, 1'b0, 1, px(0, 8'h70, 8'h60, 8'h80), '0);
    add(7, 1, 16'h8090, 1'b1, 1, px(1, 8'h90, 8'h60, 8'h80), '0);

    s_valid = '0; s_data = '0; s_last = '0; m_ready = 2'b11;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_m_valid_dut%0d", d), {31'd0, m_valid_o[d]}, 32'd0);
      chk($sformatf("reset_m_data_dut%0d", d), {8'd0, m_data_o[d]}, 32'd0);
      chk($sformatf("reset_m_last_dut%0d", d), {31'd0, m_last_o[d]}, 32'd0);
      chk($sformatf("reset_err_odd_dut%0d", d), {31'd0, err_o[d]}, 32'd0);
      chk($sformatf("reset_s_ready_dut%0d", d), {31'd0, s_ready_o[d]}, 32'd1);
    end

    run_grp(1);
    run_grp(2);
    wait_drain();
    run_grp(3);
    wait_drain();

    fork
      run_grp(4);
      stall_check();
    join
    wait_drain();

    run_grp(5);
    wait_drain();
    chk("err_odd_set_dut0", {31'd0, err_o[0]}, 32'd1);
    chk("err_odd_clear_dut1", {31'd0, err_o[1]}, 32'd0);
    run_grp(6);
    wait_drain();
    chk("err_odd_sticky_dut0", {31'd0, err_o[0]}, 32'd1);

    // Mid-line reset: pair emitted and held, Cb word sitting in H
    m_ready[1] = 1'b0;
    send_word(1, 16'h4010, 1'b0);
    send_word(1, 16'hC020, 1'b0);
    send_word(1, 16'h5030, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_m_valid_dut1", {31'd0, m_valid_o[1]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_m_valid", {31'd0, m_valid_o[1]}, 32'd0);
    chk("async_reset_m_data", {8'd0, m_data_o[1]}, 32'd0);
    chk("async_reset_s_ready", {31'd0, s_ready_o[1]}, 32'd1);
    chk("async_reset_err_odd_dut0", {31'd0, err_o[0]}, 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 m_ready[1] = 1'b1;
    run_grp(7);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
